// File: rtl/hazard_ctrl_p.sv
// Hazard controller for the five-stage RV32I pipeline: load-use/RAW stall detection,
// timed flush after a control redirect, and saturating stall/flush profiling counters.
module hazard_ctrl_p #(
  parameter int FWD_EN    = 1,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_id,
  input  logic             valid_id,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rd_mem,
  input  logic [4:0]       rd_wb,
  input  logic             wen_ex,
  input  logic             wen_mem,
  input  logic             wen_wb,
  input  logic             load_ex,
  input  logic             load_mem,
  input  logic             redirect,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             flush_id,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] FLUSH_RLD = 3'(FLUSH_CYC - 1);
  localparam logic [1:0] WAIT_LD   = 2'((LOAD_LAT >= 3) ? (LOAD_LAT - 2) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       flush_left_reg, flush_left_next;
  logic [1:0]       wait_reg, wait_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       use_rs1, use_rs2;
  logic       match_ex, match_mem;
  logic       hazard, mem_hold;
  logic       stall, flush;

  assign opcode = inst_id[6:0];
  assign rs1    = inst_id[19:15];
  assign rs2    = inst_id[24:20];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_S, OP_B: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // x0 producers never match because rd must be nonzero.
  assign match_ex  = wen_ex && (rd_ex != 5'd0) &&
                     ((use_rs1 && (rd_ex == rs1)) || (use_rs2 && (rd_ex == rs2)));
  assign match_mem = wen_mem && (rd_mem != 5'd0) &&
                     ((use_rs1 && (rd_mem == rs1)) || (use_rs2 && (rd_mem == rs2)));

  generate
    if (FWD_EN != 0) begin : g_fwd
      assign hazard   = valid_id && ((load_ex && match_ex) ||
                                     ((LOAD_LAT >= 2) && load_mem && match_mem));
      assign mem_hold = valid_id && (LOAD_LAT >= 3) && load_mem && match_mem;
    end else begin : g_nofwd
      assign hazard   = valid_id && (match_ex || match_mem);
      assign mem_hold = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    flush_left_next = flush_left_reg;
    wait_next       = wait_reg;
    stall           = 1'b0;
    flush           = 1'b0;
    if (redirect) begin
      // The instruction in ID is wrong-path, so a redirect overrides any stall.
      flush           = 1'b1;
      wait_next       = 2'd0;
      flush_left_next = FLUSH_RLD;
      state_next      = (FLUSH_CYC > 1) ? FLUSH : IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hazard) begin
            stall      = 1'b1;
            state_next = STALL;
            if (mem_hold) wait_next = WAIT_LD;
          end
        end
        STALL: begin
          if (hazard || (wait_reg != 2'd0)) begin
            stall = 1'b1;
            if (mem_hold)               wait_next = WAIT_LD;
            else if (wait_reg != 2'd0)  wait_next = wait_reg - 2'd1;
          end else begin
            state_next = IDLE;
          end
        end
        FLUSH: begin
          flush = 1'b1;
          if (flush_left_reg <= 3'd1) state_next = IDLE;
          else                        flush_left_next = flush_left_reg - 3'd1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      flush_left_reg <= 3'd0;
      wait_reg       <= 2'd0;
      stall_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      flush_left_reg <= flush_left_next;
      wait_reg       <= wait_next;
      if (stall && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  // Combinational outputs are gated so everything reads 0 during reset.
  assign stall_if  = rst_n && stall;
  assign stall_id  = rst_n && stall;
  assign bubble_ex = rst_n && stall;
  assign flush_if  = rst_n && flush;
  assign flush_id  = rst_n && flush;
  assign busy      = rst_n && (state_reg != IDLE);
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

  logic unused_bits;
  assign unused_bits = ^{inst_id[31:25], inst_id[14:7], rd_wb, wen_wb, load_ex, load_mem};

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Randomised bench for hazard_ctrl_p: two parameterisations share stimulus and are
// checked every cycle against a behavioural model, plus directed corner cases.
module tb_hazard_ctrl_p;

  localparam int A_FWD = 1, A_LAT = 1, A_FC = 2, A_CW = 16;
  localparam int B_FWD = 0, B_LAT = 1, B_FC = 3, B_CW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_id;
  logic        valid_id;
  logic [4:0]  rd_ex, rd_mem, rd_wb;
  logic        wen_ex, wen_mem, wen_wb, load_ex, load_mem, redirect;

  logic a_stall_if, a_stall_id, a_bubble_ex, a_flush_if, a_flush_id, a_busy;
  logic [A_CW-1:0] a_stall_cnt, a_flush_cnt;
  logic b_stall_if, b_stall_id, b_bubble_ex, b_flush_if, b_flush_id, b_busy;
  logic [B_CW-1:0] b_stall_cnt, b_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_p #(.FWD_EN(A_FWD), .LOAD_LAT(A_LAT), .FLUSH_CYC(A_FC), .CNT_W(A_CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .valid_id(valid_id),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .wen_ex(wen_ex), .wen_mem(wen_mem), .wen_wb(wen_wb),
    .load_ex(load_ex), .load_mem(load_mem), .redirect(redirect),
    .stall_if(a_stall_if), .stall_id(a_stall_id), .bubble_ex(a_bubble_ex),
    .flush_if(a_flush_if), .flush_id(a_flush_id), .busy(a_busy),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_ctrl_p #(.FWD_EN(B_FWD), .LOAD_LAT(B_LAT), .FLUSH_CYC(B_FC), .CNT_W(B_CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .valid_id(valid_id),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .wen_ex(wen_ex), .wen_mem(wen_mem), .wen_wb(wen_wb),
    .load_ex(load_ex), .load_mem(load_mem), .redirect(redirect),
    .stall_if(b_stall_if), .stall_id(b_stall_id), .bubble_ex(b_bubble_ex),
    .flush_if(b_flush_if), .flush_id(b_flush_id), .busy(b_busy),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: flush_left = FLUSH-state cycles still to come, stalling = in a stall episode,
  // hold = extra stall cycles owed after a slow load leaves MEM.
  typedef struct packed {
    int flush_left;
    bit stalling;
    int hold;
    int scnt;
    int fcnt;
  } model_t;

  model_t ma, mb;

  function automatic bit src_hit(input logic wen, input logic [4:0] rd);
    logic [6:0] op;
    bit two, one;
    op  = inst_id[6:0];
    two = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    one = two || (op inside {7'b0010011, 7'b0000011, 7'b1100111});
    return wen && rd != 0 && ((one && rd == inst_id[19:15]) || (two && rd == inst_id[24:20]));
  endfunction

  function automatic bit model_hazard(input int fwd, input int lat);
    if (!valid_id) return 1'b0;
    if (fwd != 0)
      return (load_ex && src_hit(wen_ex, rd_ex)) || (lat >= 2 && load_mem && src_hit(wen_mem, rd_mem));
    return src_hit(wen_ex, rd_ex) || src_hit(wen_mem, rd_mem);
  endfunction

  function automatic void model_out(input model_t m, input int fwd, input int lat,
                                    output bit st, output bit fl, output bit bz);
    st = 1'b0; fl = 1'b0; bz = 1'b0;
    if (rst_n) begin
      bz = (m.flush_left > 0) || m.stalling;
      if (redirect || m.flush_left > 0) fl = 1'b1;
      else st = model_hazard(fwd, lat) || (m.stalling && m.hold > 0);
    end
  endfunction

  function automatic model_t model_next(input model_t m, input int fwd, input int lat,
                                        input int fc, input int cw);
    model_t n;
    bit st, fl, bz;
    int maxv;
    n = m;
    maxv = (1 << cw) - 1;
    if (!rst_n) return '0;
    model_out(m, fwd, lat, st, fl, bz);
    if (st && n.scnt < maxv) n.scnt++;
    if (fl && n.fcnt < maxv) n.fcnt++;
    if (redirect) begin
      n.flush_left = fc - 1; n.stalling = 0; n.hold = 0;
    end else if (m.flush_left > 0) begin
      n.flush_left = m.flush_left - 1;
    end else begin
      n.stalling = st;
      if (st && fwd != 0 && lat >= 3 && valid_id && load_mem && src_hit(wen_mem, rd_mem))
        n.hold = lat - 2;
      else if (st && m.hold > 0) n.hold = m.hold - 1;
      else n.hold = 0;
    end
    return n;
  endfunction

  task automatic sample();
    bit st, fl, bz;
    #4;
    model_out(ma, A_FWD, A_LAT, st, fl, bz);
    check("a_stall_if", a_stall_if, st);
    check("a_stall_id", a_stall_id, st);
    check("a_bubble_ex", a_bubble_ex, st);
    check("a_flush_if", a_flush_if, fl);
    check("a_flush_id", a_flush_id, fl);
    check("a_busy", a_busy, bz);
    check("a_stall_cnt", a_stall_cnt, rst_n ? ma.scnt : 0);
    check("a_flush_cnt", a_flush_cnt, rst_n ? ma.fcnt : 0);
    model_out(mb, B_FWD, B_LAT, st, fl, bz);
    check("b_stall_if", b_stall_if, st);
    check("b_stall_id", b_stall_id, st);
    check("b_bubble_ex", b_bubble_ex, st);
    check("b_flush_if", b_flush_if, fl);
    check("b_flush_id", b_flush_id, fl);
    check("b_busy", b_busy, bz);
    check("b_stall_cnt", b_stall_cnt, rst_n ? mb.scnt : 0);
    check("b_flush_cnt", b_flush_cnt, rst_n ? mb.fcnt : 0);
  endtask

  task automatic advance();
    ma = model_next(ma, A_FWD, A_LAT, A_FC, A_CW);
    mb = model_next(mb, B_FWD, B_LAT, B_FC, B_CW);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic drive(input logic [31:0] inst, input logic v,
                       input logic [4:0] re, input logic [4:0] rm, input logic [4:0] rw,
                       input logic we, input logic wm, input logic ww,
                       input logic le, input logic lm, input logic rdr);
    inst_id = inst; valid_id = v; rd_ex = re; rd_mem = rm; rd_wb = rw;
    wen_ex = we; wen_mem = wm; wen_wb = ww; load_ex = le; load_mem = lm; redirect = rdr;
  endtask

  localparam logic [31:0] I_ADD  = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] I_LUI  = {20'h12345, 5'd5, 7'b0110111};
  localparam logic [31:0] I_ADDI = {12'd1, 5'd0, 3'd0, 5'd6, 7'b0010011};
  localparam logic [31:0] I_SW   = {7'd0, 5'd5, 5'd8, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] I_BEQ  = {7'd0, 5'd4, 5'd3, 3'd0, 5'd0, 7'b1100011};

  task automatic idle(input logic rdr);
    drive(32'h13, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, rdr);
  endtask

  initial begin
    logic [6:0] ops [9];
    logic [6:0] op;
    ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111};
    ma = '0; mb = '0;
    rst_n = 1'b0;
    idle(1'b0);
    @(posedge clk); #1;
    tick();
    rst_n = 1'b1;
    sample();
    check("rst_a_stall_cnt", a_stall_cnt, 0);
    check("rst_a_busy", a_busy, 0);
    advance();

    // Load-use: lw x5 in EX, add x6,x5,x7 in ID
    drive(I_ADD, 1, 5, 0, 0, 1, 0, 0, 1, 0, 0);
    sample(); check("lu_stall", a_stall_if, 1); advance();
    drive(I_ADD, 1, 0, 5, 0, 0, 1, 0, 0, 1, 0);
    sample(); check("lu_release", a_stall_if, 0); check("lu_stall_cnt", a_stall_cnt, 1); advance();
    // No-source and x0 cases
    drive(I_LUI, 1, 5, 0, 0, 1, 0, 0, 1, 0, 0);
    sample(); check("lui_nostall", a_stall_if, 0); advance();
    drive(I_ADDI, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    sample(); check("x0_nostall", a_stall_if, 0); advance();
    drive(I_SW, 1, 5, 0, 0, 1, 0, 0, 1, 0, 0);
    sample(); check("sw_rs2_stall", a_stall_if, 1); advance();
    idle(0); tick();

    // No forwarding: add x3 in EX, beq x3,x4 in ID
    drive(I_BEQ, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
    sample(); check("nofwd_ex", b_stall_if, 1); advance();
    drive(I_BEQ, 1, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    sample(); check("nofwd_mem", b_stall_if, 1); advance();
    drive(I_BEQ, 1, 0, 0, 3, 0, 0, 1, 0, 0, 0);
    sample(); check("nofwd_wb", b_stall_if, 0); advance();
    idle(0); tick(); tick(); tick();

    // Redirect while a hazard is present
    drive(I_ADD, 1, 5, 0, 0, 1, 0, 0, 1, 0, 0); tick();
    redirect = 1'b1;
    sample(); check("rdr_stall", a_stall_if, 0); check("rdr_flush", a_flush_id, 1); advance();
    redirect = 1'b0;
    sample(); check("flush2", a_flush_if, 1); check("flush2_busy", a_busy, 1); advance();
    idle(0);
    sample(); check("flush_done", a_flush_id, 0); check("flush_cnt2", a_flush_cnt, 2);
    check("flush_idle", a_busy, 0); advance();
    idle(0); tick(); tick();

    // Back-to-back redirect
    idle(1); tick();
    idle(1); tick();
    idle(0); sample(); check("b2b_third", a_flush_id, 1); advance();
    sample(); check("b2b_done", a_flush_id, 0); check("b2b_cnt", a_flush_cnt, 5); advance();
    tick(); tick();

    // Asynchronous reset mid-STALL
    drive(I_ADD, 1, 5, 0, 0, 1, 0, 0, 1, 0, 0); tick();
    rst_n = 1'b0;
    sample(); check("rst_stall_out", a_stall_if, 0); check("rst_stall_busy", a_busy, 0); advance();
    rst_n = 1'b1; idle(0);
    sample(); check("rst_stall_cnt0", a_stall_cnt, 0); advance();

    // Asynchronous reset mid-FLUSH
    idle(1); tick();
    idle(0);
    rst_n = 1'b0;
    sample(); check("rst_flush_out", a_flush_id, 0); advance();
    rst_n = 1'b1;
    sample(); check("rst_flush_cnt0", a_flush_cnt, 0); check("rst_flush_busy", a_busy, 0); advance();

    // Saturation of the 4-bit counter
    drive(I_BEQ, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
    repeat (20) tick();
    sample(); check("sat15", b_stall_cnt, 15); advance();

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k == 9) op = 7'($urandom);
      else op = ops[k];
      drive({7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             3'($urandom), 5'($urandom_range(0, 3)), op},
            ($urandom_range(0, 7) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
